// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
package debounce_pkg;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 25;
    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

    typedef int unsigned width_t;

    // Counter only has to reach STABLE_CYCLES-1, so clog2 of the threshold is enough.
    function automatic width_t cnt_width(input int unsigned stable_cycles);
        return (stable_cycles < 2) ? width_t'(1) : width_t'($clog2(stable_cycles));
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: input synchronizer, stability counter, debounced
// state and registered rise/fall event pulses.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter logic        INIT_LEVEL    = 1'b0,
    parameter int unsigned CNT_W         = cnt_width(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic db_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // Any sample agreeing with the current state restarts qualification.
        if (sync_out == db_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                db_d   = sync_out;
                cnt_d  = '0;
                rise_d = sync_out;
                fall_d = ~sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q  <= '0;
            db_q   <= INIT_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_out = db_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign busy   = (cnt_q != '0);

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch/button debouncer; each bit of din gets an independent
// debounce_ch sharing clk, reset and the prescaler tick.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] busy
);

    localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_ch #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .SYNC_STAGES   (SYNC_STAGES),
                .INIT_LEVEL    (INIT_LEVEL),
                .CNT_W         (CNT_W)
            ) u_ch (
                .clk    (clk),
                .rst_n  (rst_n),
                .tick   (tick),
                .din    (din[gi]),
                .db_out (db_out[gi]),
                .rise   (rise[gi]),
                .fall   (fall[gi]),
                .busy   (busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (4 channels, threshold 4, 2 sync stages),
// plus a second instance reset to level 1.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] din;
    logic [3:0] din2;
    logic [3:0] db_out, rise, fall, busy;
    logic [3:0] db_out2, rise2, fall2, busy2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .INIT_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .din(din),
        .db_out(db_out), .rise(rise), .fall(fall), .busy(busy)
    );

    debounce_multi #(
        .N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .INIT_LEVEL(1'b1)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .tick(tick), .din(din2),
        .db_out(db_out2), .rise(rise2), .fall(fall2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick  = 1'b1;
        din   = 4'hF;
        din2  = 4'hF;

        // Reset with inputs high
        repeat (3) step();
        chk("rst_db",    32'(db_out), 32'h0);
        chk("rst_rise",  32'(rise),   32'h0);
        chk("rst_fall",  32'(fall),   32'h0);
        chk("rst_busy",  32'(busy),   32'h0);
        chk("rst_db_hi", 32'(db_out2), 32'hF);
        $display("reset: db=%h rise=%h fall=%h busy=%h db_hi=%h", db_out, rise, fall, busy, db_out2);

        din   = 4'h0;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("idle_db",     32'(db_out), 32'h0);
            chk("idle_busy",   32'(busy),   32'h0);
            chk("hi_db",       32'(db_out2), 32'hF);
            chk("hi_rise",     32'(rise2),  32'h0);
            chk("hi_fall",     32'(fall2),  32'h0);
            $display("post-reset k=%0d db=%h busy=%h db_hi=%h rise_hi=%h fall_hi=%h", k, db_out, busy, db_out2, rise2, fall2);
        end

        // Clean press on channel 0
        din = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("press_busy0", 32'(busy[0]),   32'((k >= 3 && k <= 5) ? 1 : 0));
            chk("press_db0",   32'(db_out[0]), 32'((k >= 6) ? 1 : 0));
            chk("press_rise0", 32'(rise[0]),   32'((k == 6) ? 1 : 0));
            chk("press_fall0", 32'(fall[0]),   32'h0);
            $display("press k=%0d db=%h rise=%h busy=%h", k, db_out, rise, busy);
        end
        chk("press_others", 32'(db_out[3:1]), 32'h0);

        // Glitch of 3 cycles on channel 1
        din = 4'b0011;
        repeat (3) step();
        din = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("glitch_db1",   32'(db_out[1]), 32'h0);
            chk("glitch_rise1", 32'(rise[1]),   32'h0);
            $display("glitch k=%0d db=%h rise=%h busy=%h", k, db_out, rise, busy);
        end
        chk("glitch_busy1", 32'(busy[1]), 32'h0);

        // Four-cycle press on channel 1 is enough
        din = 4'b0011;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("press1_db1",   32'(db_out[1]), 32'((k == 6) ? 1 : 0));
            chk("press1_rise1", 32'(rise[1]),   32'((k == 6) ? 1 : 0));
            $display("press1 k=%0d db=%h rise=%h", k, db_out, rise);
        end

        // Channel 2 high, then bounce and release
        din = 4'b0111;
        repeat (6) step();
        chk("ch2_up", 32'(db_out[2]), 32'h1);
        for (int k = 0; k < 3; k++) begin
            din[2] = (k % 2 == 0) ? 1'b1 : 1'b0;
            step();
            chk("bounce_db2",   32'(db_out[2]), 32'h1);
            chk("bounce_fall2", 32'(fall[2]),   32'h0);
            $display("bounce k=%0d din=%h db=%h fall=%h", k, din, db_out, fall);
        end
        din[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("rel_db2",   32'(db_out[2]), 32'((k < 6) ? 1 : 0));
            chk("rel_fall2", 32'(fall[2]),   32'((k == 6) ? 1 : 0));
            chk("rel_rise2", 32'(rise[2]),   32'h0);
            $display("release k=%0d db=%h fall=%h", k, db_out, fall);
        end

        // Tick every 3rd cycle on channel 3
        din = 4'b1011;
        for (int k = 1; k <= 13; k++) begin
            tick = (k % 3 == 0);
            step();
            chk("tick_db3",   32'(db_out[3]), 32'((k >= 12) ? 1 : 0));
            chk("tick_rise3", 32'(rise[3]),   32'((k == 12) ? 1 : 0));
            chk("tick_busy3", 32'(busy[3]),   32'((k >= 3 && k < 12) ? 1 : 0));
            $display("tick3 k=%0d tick=%0b db=%h rise=%h busy=%h", k, tick, db_out, rise, busy);
        end

        // Release channel 3, then stall tick mid-count
        din  = 4'b0011;
        tick = 1'b1;
        repeat (4) step();
        chk("stall_busy_pre", 32'(busy[3]), 32'h1);
        tick = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("stall_db3",   32'(db_out[3]), 32'h1);
            chk("stall_fall3", 32'(fall[3]),   32'h0);
            chk("stall_busy3", 32'(busy[3]),   32'h1);
            $display("stall k=%0d db=%h fall=%h busy=%h", k, db_out, fall, busy);
        end
        tick = 1'b1;
        step();
        chk("resume_db3_a",   32'(db_out[3]), 32'h1);
        step();
        chk("resume_db3_b",   32'(db_out[3]), 32'h0);
        chk("resume_fall3",   32'(fall[3]),   32'h1);
        $display("resume db=%h fall=%h", db_out, fall);

        // Settle everything low, then reset mid-count on channel 0
        din = 4'b0000;
        repeat (8) step();
        chk("settle_db", 32'(db_out), 32'h0);
        din = 4'b0001;
        repeat (4) step();
        chk("mid_busy0", 32'(busy[0]), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy),   32'h0);
        chk("midrst_db",   32'(db_out), 32'h0);
        chk("midrst_rise", 32'(rise),   32'h0);
        $display("mid-reset db=%h rise=%h busy=%h", db_out, rise, busy);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("after_db0",   32'(db_out[0]), 32'((k >= 6) ? 1 : 0));
            chk("after_rise0", 32'(rise[0]),   32'((k == 6) ? 1 : 0));
            $display("after-reset k=%0d db=%h rise=%h", k, db_out, rise);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel switch/button debouncer, successor to the single-channel rise-only debouncer.
- Per channel: a synchronizer for asynchronous inputs, and symmetric press/release filtering with a programmable stability threshold.
- A tick enable lets the filter run from a shared prescaler, and the block emits one-cycle rise/fall event pulses.
- Sits between board pins (buttons/switches) and FSM/control logic.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- STABLE_CYCLES, 25, consecutive qualifying ticks an input must differ from the debounced state before the state flips (>=2).
- SYNC_STAGES, 2, synchronizer flops per channel (>=2).
- INIT_LEVEL, 0, reset level of synchronizer flops and debounced outputs (all channels).
- CNT_W, $clog2(STABLE_CYCLES), derived counter width, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tick  in  1  filter enable; counters advance only when 1 (tie to 1 for per-clock filtering).
- din  in  N_CH  raw asynchronous inputs.
- db_out  out  N_CH  debounced levels.
- rise  out  N_CH  one-cycle pulse on the cycle db_out goes 0->1.
- fall  out  N_CH  one-cycle pulse on the cycle db_out goes 1->0.
- busy  out  N_CH  1 while the channel counter is non-zero (change pending).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - sync flops and db_out = INIT_LEVEL.
  - counters = 0.
  - rise, fall, busy = 0.
  - Reset overrides tick and din.
  - Reset mid-count discards the pending count; no pulse is generated.
- Synchronizer: sync_out[i] is din[i] delayed SYNC_STAGES clocks. It runs every clock, independent of tick.
- Per channel, each rising edge with rst_n=1:
  - sync_out == db_out: counter <= 0, regardless of tick. Any glitch resets the filter.
  - sync_out != db_out, tick=0: counter holds.
  - sync_out != db_out, tick=1, counter < STABLE_CYCLES-1: counter <= counter+1.
  - sync_out != db_out, tick=1, counter == STABLE_CYCLES-1:
    - db_out <= sync_out;
    - counter <= 0;
    - rise (or fall) <= 1 for exactly this one cycle.
  - rise/fall are registered, asserted the same cycle db_out changes, and otherwise 0. rise and fall are never both 1 on the same channel.
- busy = (counter != 0), combinational from the counter register.
- Latency (tick=1 continuously): db_out changes on the (SYNC_STAGES+STABLE_CYCLES)th rising edge, counting the edge that first samples the new din level as edge 1. For the defaults this is 27 edges.
- Pulses narrower than STABLE_CYCLES qualifying ticks, as seen at sync_out, never change db_out.
- Symmetric: identical filtering for press and release.
- Channels are fully independent; simultaneous flips on several channels are allowed.
- Counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.

Decomposition:
- Shared package, debounce_pkg:
  - default STABLE_CYCLES and SYNC_STAGES constants;
  - typedef for the counter width function.
- Sub-module: debounce_ch (one synchronizer + counter + state + edge regs), instantiated N_CH times by a generate loop in debounce_multi. Top level only does fan-out of clk/rst_n/tick and bit slicing.

Test Plan (N_CH=4, STABLE_CYCLES=4, SYNC_STAGES=2, INIT_LEVEL=0 unless stated):
- Reset: hold rst_n=0 for 3 cycles with din=4'hF -> db_out=0, rise=fall=busy=0. With INIT_LEVEL=1 -> db_out=4'hF and no rise/fall pulses after release.
- Clean press, tick=1: din[0] 0->1 and held -> db_out[0]=1 on edge 6 with rise[0]=1 for exactly one cycle. busy[0]=1 from edge 3 to edge 5. Other channels unchanged.
- Glitch rejection: din[1]=1 for 3 cycles then 0 -> db_out[1] stays 0, rise[1] never asserts, busy[1] returns to 0. Then din[1]=1 for 4 cycles -> db_out[1] rises.
- Release and bounce: db_out[2]=1; din[2] toggles 1,0,1,0 each cycle, then 0 held -> db_out[2]=1 throughout the toggling. It falls with fall[2] one-cycle pulse 6 edges after the final 1->0.
- Tick gating: tick=1 every 3rd cycle, din[3] 0->1 held -> db_out[3] rises only after 4 tick-qualified increments; the counter holds on tick=0 cycles. Drop tick entirely mid-count with din[3] still 1 -> no change.
- Reset mid-count: din[0]=1, assert rst_n=0 at counter=2 for 1 cycle -> counter=0, no pulse. After release, full 6-edge latency is required again.
